// File: rtl/lnrv_exu_pkg.sv
// Shared EXU definitions: flush controller state encodings and redirect alignment mask.
package lnrv_exu_pkg;

  typedef enum logic [1:0] {
    FLUSH_IDLE  = 2'd0,
    FLUSH_REQ   = 2'd1,
    FLUSH_DRAIN = 2'd2
  } flush_state_e;

  // Redirect targets are halfword aligned; bit 0 is always cleared.
  localparam logic [31:0] FLUSH_PC_ALIGN_MASK = 32'hFFFF_FFFE;

endpackage

// File: rtl/lnrv_flush_tgt_gen.sv
// Redirect target generator: op1 + op2 (mod 2^32) with bit 0 cleared.
module lnrv_flush_tgt_gen
  import lnrv_exu_pkg::*;
(
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  output logic [31:0] tgt
);

  logic [31:0] sum;

  assign sum = op1 + op2;
  assign tgt = sum & FLUSH_PC_ALIGN_MASK;

endmodule

// File: rtl/lnrv_exu_flush_ctrl.sv
// EXU flush controller: arbitrates exception/branch redirects, drives the IFU redirect and pipe_kill.
// Optional accepted-flush counter enabled with `define LNRV_FLUSH_CNT_EN.
module lnrv_exu_flush_ctrl
  import lnrv_exu_pkg::*;
#(
  parameter int unsigned DRAIN_CYC = 2,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             excp_flush_req,
  output logic             excp_flush_ack,
  input  logic [31:0]      excp_pc_op1,
  input  logic [31:0]      excp_pc_op2,
  input  logic             bru_flush_req,
  output logic             bru_flush_ack,
  input  logic [31:0]      bru_pc_op1,
  input  logic [31:0]      bru_pc_op2,
  output logic             ifu_flush_vld,
  input  logic             ifu_flush_rdy,
  output logic [31:0]      ifu_flush_pc,
  output logic             pipe_kill,
  output logic             busy,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned DRAIN_W = 4;
  localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(DRAIN_CYC - 1);

  flush_state_e       state_q, state_d;
  logic               vld_q, vld_d;
  logic [31:0]        pc_q, pc_d;
  logic               kill_q, kill_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic               idle;
  logic               accept;
  logic [31:0]        tgt_op1, tgt_op2, tgt_pc;

  assign idle           = (state_q == FLUSH_IDLE);
  assign excp_flush_ack = idle && excp_flush_req;
  assign bru_flush_ack  = idle && !excp_flush_req && bru_flush_req;
  assign accept         = excp_flush_ack || bru_flush_ack;

  // Single adder shared by both sources; the mux follows the ack priority.
  assign tgt_op1 = excp_flush_req ? excp_pc_op1 : bru_pc_op1;
  assign tgt_op2 = excp_flush_req ? excp_pc_op2 : bru_pc_op2;

  lnrv_flush_tgt_gen u_tgt_gen (
    .op1 (tgt_op1),
    .op2 (tgt_op2),
    .tgt (tgt_pc)
  );

  always_comb begin
    state_d = state_q;
    vld_d   = vld_q;
    pc_d    = pc_q;
    kill_d  = kill_q;
    drain_d = drain_q;
    unique case (state_q)
      FLUSH_IDLE: begin
        if (accept) begin
          pc_d    = tgt_pc;
          vld_d   = 1'b1;
          kill_d  = 1'b1;
          state_d = FLUSH_REQ;
        end
      end
      FLUSH_REQ: begin
        if (ifu_flush_rdy) begin
          vld_d   = 1'b0;
          drain_d = DRAIN_INIT;
          state_d = FLUSH_DRAIN;
        end
      end
      FLUSH_DRAIN: begin
        if (drain_q == '0) begin
          kill_d  = 1'b0;
          state_d = FLUSH_IDLE;
        end else begin
          drain_d = drain_q - DRAIN_W'(1);
        end
      end
      default: begin
        state_d = FLUSH_IDLE;
        vld_d   = 1'b0;
        kill_d  = 1'b0;
        drain_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FLUSH_IDLE;
      vld_q   <= 1'b0;
      pc_q    <= '0;
      kill_q  <= 1'b0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      pc_q    <= pc_d;
      kill_q  <= kill_d;
      drain_q <= drain_d;
    end
  end

  assign ifu_flush_vld = vld_q;
  assign ifu_flush_pc  = pc_q;
  assign pipe_kill     = kill_q;
  assign busy          = !idle;

`ifdef LNRV_FLUSH_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset)       cnt_q <= '0;
    else if (accept) cnt_q <= cnt_q + CNT_W'(1);
  end

  assign flush_cnt = cnt_q;
`else
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_lnrv_exu_flush_ctrl.sv
// Self-checking bench for lnrv_exu_flush_ctrl: scoreboard of expected redirect PCs plus per-scenario checks.
module tb_lnrv_exu_flush_ctrl;

  localparam int unsigned DRAIN_CYC = 2;
  localparam int unsigned CNT_W     = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             excp_flush_req, bru_flush_req, ifu_flush_rdy;
  logic [31:0]      excp_pc_op1, excp_pc_op2, bru_pc_op1, bru_pc_op2;
  logic             excp_flush_ack, bru_flush_ack, ifu_flush_vld, pipe_kill, busy;
  logic [31:0]      ifu_flush_pc;
  logic [CNT_W-1:0] flush_cnt;

  int unsigned passed = 0;
  int unsigned total  = 0;
  int unsigned accepts = 0;
  logic [31:0] sb_q[$];

  lnrv_exu_flush_ctrl #(.DRAIN_CYC(DRAIN_CYC), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .excp_flush_req (excp_flush_req),
    .excp_flush_ack (excp_flush_ack),
    .excp_pc_op1    (excp_pc_op1),
    .excp_pc_op2    (excp_pc_op2),
    .bru_flush_req  (bru_flush_req),
    .bru_flush_ack  (bru_flush_ack),
    .bru_pc_op1     (bru_pc_op1),
    .bru_pc_op2     (bru_pc_op2),
    .ifu_flush_vld  (ifu_flush_vld),
    .ifu_flush_rdy  (ifu_flush_rdy),
    .ifu_flush_pc   (ifu_flush_pc),
    .pipe_kill      (pipe_kill),
    .busy           (busy),
    .flush_cnt      (flush_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] tgt_model(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] s;
    s    = a + b;
    s[0] = 1'b0;
    return s;
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Entered one cycle after an accept; completes the redirect and drain, optionally holding an excp request.
  task automatic run_flush(input int unsigned wait_cyc, input logic poke_excp);
    logic [31:0] exp_pc;
    int unsigned kill_n;
    int unsigned guard;
    kill_n = 0;
    exp_pc = 32'h0;
    total++;
    if (sb_q.size() == 0) $display("FAIL sb_empty: no expected redirect queued");
    else begin
      passed++;
      exp_pc = sb_q.pop_front();
    end
    if (poke_excp) begin
      excp_flush_req = 1'b1;
      excp_pc_op1    = 32'h0000_3000;
      excp_pc_op2    = 32'h0000_0008;
    end
    ifu_flush_rdy = 1'b0;
    for (int unsigned c = 0; c <= wait_cyc; c++) begin
      total++;
      if (ifu_flush_vld !== 1'b1 || ifu_flush_pc !== exp_pc || busy !== 1'b1)
        $display("FAIL req_hold: cyc=%0d vld=%b pc=%h busy=%b, want vld=1 pc=%h busy=1",
                 c, ifu_flush_vld, ifu_flush_pc, busy, exp_pc);
      else passed++;
      total++;
      if (excp_flush_ack !== 1'b0 || bru_flush_ack !== 1'b0)
        $display("FAIL req_noack: cyc=%0d excp_ack=%b bru_ack=%b, want 0/0", c, excp_flush_ack, bru_flush_ack);
      else passed++;
      if (pipe_kill) kill_n++;
      if (c == wait_cyc) ifu_flush_rdy = 1'b1;
      step();
    end
    ifu_flush_rdy = 1'b0;
    guard = 0;
    while (pipe_kill === 1'b1 && guard < 40) begin
      total++;
      if (excp_flush_ack !== 1'b0 || bru_flush_ack !== 1'b0 || ifu_flush_vld !== 1'b0)
        $display("FAIL drain: excp_ack=%b bru_ack=%b vld=%b, want 0/0/0", excp_flush_ack, bru_flush_ack, ifu_flush_vld);
      else passed++;
      kill_n++;
      guard++;
      step();
    end
    total++;
    if (kill_n !== 1 + wait_cyc + DRAIN_CYC)
      $display("FAIL kill_len: got %0d cycles, want %0d", kill_n, 1 + wait_cyc + DRAIN_CYC);
    else passed++;
    total++;
    if (busy !== 1'b0 || ifu_flush_vld !== 1'b0 || pipe_kill !== 1'b0)
      $display("FAIL back_idle: busy=%b vld=%b kill=%b, want 0/0/0", busy, ifu_flush_vld, pipe_kill);
    else passed++;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    excp_flush_req = 1'b0;
    bru_flush_req  = 1'b0;
    ifu_flush_rdy  = 1'b0;
    step();
    step();
    reset   = 1'b0;
    accepts = 0;
    sb_q.delete();
  endtask

  task automatic test_reset();
    excp_pc_op1 = '0; excp_pc_op2 = '0; bru_pc_op1 = '0; bru_pc_op2 = '0;
    do_reset();
    total++;
    if (ifu_flush_vld !== 1'b0 || ifu_flush_pc !== 32'h0 || pipe_kill !== 1'b0 || busy !== 1'b0 || flush_cnt !== '0)
      $display("FAIL reset_state: vld=%b pc=%h kill=%b busy=%b cnt=%0d, want all 0",
               ifu_flush_vld, ifu_flush_pc, pipe_kill, busy, flush_cnt);
    else passed++;
    ifu_flush_rdy = 1'b1;
    step();
    ifu_flush_rdy = 1'b0;
    total++;
    if (ifu_flush_vld !== 1'b0 || busy !== 1'b0 || excp_flush_ack !== 1'b0 || bru_flush_ack !== 1'b0)
      $display("FAIL idle_rdy: vld=%b busy=%b acks=%b%b, want 0/0/00", ifu_flush_vld, busy, excp_flush_ack, bru_flush_ack);
    else passed++;
  endtask

  task automatic test_excp_basic();
    excp_flush_req = 1'b1;
    excp_pc_op1    = 32'h8000_0100;
    excp_pc_op2    = 32'h0;
    #1;
    total++;
    if (excp_flush_ack !== 1'b1 || bru_flush_ack !== 1'b0)
      $display("FAIL excp_ack: excp_ack=%b bru_ack=%b, want 1/0", excp_flush_ack, bru_flush_ack);
    else passed++;
    sb_q.push_back(32'h8000_0100);
    accepts++;
    step();
    excp_flush_req = 1'b0;
    run_flush(0, 1'b0);
  endtask

  task automatic test_priority();
    excp_flush_req = 1'b1; excp_pc_op1 = 32'h0000_1000; excp_pc_op2 = 32'h4;
    bru_flush_req  = 1'b1; bru_pc_op1  = 32'h0000_0200; bru_pc_op2  = 32'h11;
    #1;
    total++;
    if (excp_flush_ack !== 1'b1 || bru_flush_ack !== 1'b0)
      $display("FAIL prio_ack: excp_ack=%b bru_ack=%b, want 1/0", excp_flush_ack, bru_flush_ack);
    else passed++;
    sb_q.push_back(tgt_model(32'h1000, 32'h4));
    accepts++;
    step();
    excp_flush_req = 1'b0;
    run_flush(0, 1'b0);
    total++;
    if (bru_flush_ack !== 1'b1 || excp_flush_ack !== 1'b0)
      $display("FAIL bru_late_ack: bru_ack=%b excp_ack=%b, want 1/0", bru_flush_ack, excp_flush_ack);
    else passed++;
    sb_q.push_back(32'h0000_0210);
    accepts++;
    step();
    bru_flush_req = 1'b0;
    run_flush(0, 1'b0);
  endtask

  task automatic test_rdy_stall();
    bru_flush_req = 1'b1; bru_pc_op1 = 32'h0000_4000; bru_pc_op2 = 32'h0000_0123;
    #1;
    total++;
    if (bru_flush_ack !== 1'b1)
      $display("FAIL stall_ack: bru_ack=%b, want 1", bru_flush_ack);
    else passed++;
    sb_q.push_back(tgt_model(32'h4000, 32'h123));
    accepts++;
    step();
    bru_flush_req = 1'b0;
    run_flush(5, 1'b1);
    total++;
    if (excp_flush_ack !== 1'b1)
      $display("FAIL first_idle_ack: excp_ack=%b, want 1", excp_flush_ack);
    else passed++;
    sb_q.push_back(32'h0000_3008);
    accepts++;
    step();
    excp_flush_req = 1'b0;
    run_flush(1, 1'b0);
  endtask

  task automatic test_wrap();
    bru_flush_req = 1'b1; bru_pc_op1 = 32'hFFFF_FFF0; bru_pc_op2 = 32'h14;
    #1;
    total++;
    if (bru_flush_ack !== 1'b1)
      $display("FAIL wrap_ack: bru_ack=%b, want 1", bru_flush_ack);
    else passed++;
    sb_q.push_back(32'h0000_0004);
    accepts++;
    step();
    bru_flush_req = 1'b0;
    run_flush(0, 1'b0);
  endtask

  task automatic test_reset_mid();
    excp_flush_req = 1'b1; excp_pc_op1 = 32'h0000_0500; excp_pc_op2 = 32'h0;
    step();
    excp_flush_req = 1'b0;
    total++;
    if (ifu_flush_vld !== 1'b1 || busy !== 1'b1)
      $display("FAIL pre_rst_req: vld=%b busy=%b, want 1/1", ifu_flush_vld, busy);
    else passed++;
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++;
    if (ifu_flush_vld !== 1'b0 || pipe_kill !== 1'b0 || busy !== 1'b0)
      $display("FAIL rst_in_req: vld=%b kill=%b busy=%b, want 0/0/0", ifu_flush_vld, pipe_kill, busy);
    else passed++;
    accepts = 0;
    sb_q.delete();
    bru_flush_req = 1'b1; bru_pc_op1 = 32'h0000_0600; bru_pc_op2 = 32'h0;
    #1;
    total++;
    if (bru_flush_ack !== 1'b1)
      $display("FAIL ack_after_rst1: bru_ack=%b, want 1", bru_flush_ack);
    else passed++;
    step();
    bru_flush_req = 1'b0;
    ifu_flush_rdy = 1'b1;
    step();
    ifu_flush_rdy = 1'b0;
    total++;
    if (pipe_kill !== 1'b1 || busy !== 1'b1 || ifu_flush_vld !== 1'b0)
      $display("FAIL pre_rst_drain: kill=%b busy=%b vld=%b, want 1/1/0", pipe_kill, busy, ifu_flush_vld);
    else passed++;
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++;
    if (ifu_flush_vld !== 1'b0 || pipe_kill !== 1'b0 || busy !== 1'b0)
      $display("FAIL rst_in_drain: vld=%b kill=%b busy=%b, want 0/0/0", ifu_flush_vld, pipe_kill, busy);
    else passed++;
    accepts = 0;
    excp_flush_req = 1'b1; excp_pc_op1 = 32'h0000_0701; excp_pc_op2 = 32'h0;
    #1;
    total++;
    if (excp_flush_ack !== 1'b1)
      $display("FAIL ack_after_rst2: excp_ack=%b, want 1", excp_flush_ack);
    else passed++;
    sb_q.push_back(32'h0000_0700);
    accepts++;
    step();
    excp_flush_req = 1'b0;
    run_flush(0, 1'b0);
  endtask

  task automatic test_flush_cnt();
    logic [CNT_W-1:0] exp_cnt;
    do_reset();
    for (int unsigned i = 0; i < 3; i++) begin
      bru_flush_req = 1'b1;
      bru_pc_op1    = 32'h0000_1000 * (i + 1);
      bru_pc_op2    = 32'h3;
      #1;
      sb_q.push_back(tgt_model(32'h0000_1000 * (i + 1), 32'h3));
      accepts++;
      step();
      bru_flush_req = 1'b0;
      run_flush(i, 1'b0);
    end
`ifdef LNRV_FLUSH_CNT_EN
    exp_cnt = CNT_W'(accepts);
`else
    exp_cnt = '0;
`endif
    total++;
    if (flush_cnt !== exp_cnt)
      $display("FAIL flush_cnt: got %0d, want %0d", flush_cnt, exp_cnt);
    else passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_excp_basic();
    test_priority();
    test_rdy_stall();
    test_wrap();
    test_reset_mid();
    test_flush_cnt();
    total++;
    if (sb_q.size() != 0)
      $display("FAIL sb_leftover: %0d entries, want 0", sb_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
